// File: rtl/rv32imf_div_iter.sv
// Iterative RV32IM divider/remainder unit: restoring division on operand magnitudes,
// BITS_PER_CYCLE quotient bits per iteration, valid/ready on both sides, kill and fast path.
module rv32imf_div_iter #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned CNT_WIDTH      = $clog2(WIDTH / BITS_PER_CYCLE) + 1
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Kill_SI,
  input  logic [WIDTH-1:0] OpA_DI,
  input  logic [WIDTH-1:0] OpB_DI,
  input  logic [1:0]       OpCode_SI,
  input  logic             InVld_SI,
  output logic             InRdy_SO,
  output logic             OutVld_SO,
  input  logic             OutRdy_SI,
  output logic [WIDTH-1:0] Res_DO
);

  localparam int unsigned NumIter = WIDTH / BITS_PER_CYCLE;
  localparam logic [CNT_WIDTH-1:0] CntInit = CNT_WIDTH'(NumIter);

  typedef enum logic [1:0] {StIdle, StDivide, StFinish} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]       rem_q, rem_d;
  // Holds the dividend magnitude; quotient bits shift in from the LSB as dividend bits leave.
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 is_rem_q, is_rem_d;
  logic                 neg_q, neg_d;

  logic             a_neg, b_neg, b_zero, accept, in_rdy;
  logic [WIDTH-1:0] a_mag, b_mag, res_mag;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  always_comb begin
    a_neg  = OpCode_SI[0] & OpA_DI[WIDTH-1];
    b_neg  = OpCode_SI[0] & OpB_DI[WIDTH-1];
    a_mag  = a_neg ? (~OpA_DI + 1'b1) : OpA_DI;
    b_mag  = b_neg ? (~OpB_DI + 1'b1) : OpB_DI;
    b_zero = (OpB_DI == '0);
    in_rdy = (state_q == StIdle) & ~Kill_SI;
    accept = in_rdy & InVld_SI;
  end

  // Unrolled restoring steps on the registered partial remainder.
  always_comb begin
    rem_step = rem_q;
    quo_step = quo_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_step = {rem_step[WIDTH-1:0], quo_step[WIDTH-1]};
      quo_step = {quo_step[WIDTH-2:0], 1'b0};
      if (rem_step >= {1'b0, div_q}) begin
        rem_step    = rem_step - {1'b0, div_q};
        quo_step[0] = 1'b1;
      end
    end
  end

  always_comb begin
    res_mag = is_rem_q ? rem_q[WIDTH-1:0] : quo_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    res_d    = res_q;
    is_rem_d = is_rem_q;
    neg_d    = neg_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          is_rem_d = OpCode_SI[1];
          neg_d    = OpCode_SI[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero);
          cnt_d    = CntInit;
          rem_d    = '0;
          quo_d    = a_mag;
          div_d    = b_mag;
          if (b_zero || (a_mag < b_mag)) begin
            res_d   = OpCode_SI[1] ? OpA_DI : (b_zero ? '1 : '0);
            state_d = StFinish;
          end else begin
            state_d = StDivide;
          end
        end
      end
      StDivide: begin
        if (cnt_q != '0) begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Sign correction from registered results keeps it off the iteration path.
          res_d   = neg_q ? (~res_mag + 1'b1) : res_mag;
          state_d = StFinish;
        end
      end
      StFinish: begin
        if (OutRdy_SI) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (Kill_SI) begin
      state_d = StIdle;
      res_d   = res_q;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      res_q    <= '0;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      res_q    <= res_d;
      is_rem_q <= is_rem_d;
      neg_q    <= neg_d;
    end
  end

  assign InRdy_SO  = in_rdy;
  assign OutVld_SO = (state_q == StFinish);
  assign Res_DO    = res_q;

endmodule

// File: tb/tb_rv32imf_div_iter.sv
// Scoreboard bench for rv32imf_div_iter built with four quotient bits per cycle.
module tb_rv32imf_div_iter;

  localparam int unsigned Width   = 32;
  localparam int unsigned Bpc     = 4;
  localparam int unsigned NumIter = Width / Bpc;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              kill;
  logic [Width-1:0]  opa, opb;
  logic [1:0]        opcode;
  logic              in_vld, in_rdy, out_vld, out_rdy;
  logic [Width-1:0]  res;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  rv32imf_div_iter #(
    .WIDTH         (Width),
    .BITS_PER_CYCLE(Bpc)
  ) u_dut (
    .Clk_CI   (clk),
    .Rst_RBI  (rst_n),
    .Kill_SI  (kill),
    .OpA_DI   (opa),
    .OpB_DI   (opb),
    .OpCode_SI(opcode),
    .InVld_SI (in_vld),
    .InRdy_SO (in_rdy),
    .OutVld_SO(out_vld),
    .OutRdy_SI(out_rdy),
    .Res_DO   (res)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  // RISC-V M-extension reference semantics.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10: return (b == 0) ? a : a % b;
      2'b01: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
    endcase
  endfunction

  // Latency is counted in clock edges from the accept edge to OutVld: N+1 on the normal
  // path, none on the fast path (result shows in the cycle right after accept).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] exp, input int stall);
    int          wait_cyc, k, low, bad;
    logic [31:0] held, exp_res;
    logic        fast;
    fast = (b == 0) || (mag(a, op[0]) < mag(b, op[0]));
    @(negedge clk);
    opa     = a;
    opb     = b;
    opcode  = op;
    in_vld  = 1'b1;
    out_rdy = (stall == 0);
    wait_cyc = 0;
    while (!in_rdy && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!in_rdy) begin
      check_val("accept_timeout", 32'(in_rdy), 32'd1);
      in_vld = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(exp);
    lat_q.push_back(fast ? 0 : int'(NumIter) + 1);
    #1;
    in_vld = 1'b0;
    opa    = $urandom;
    opb    = $urandom;
    opcode = 2'($urandom);
    k   = 0;
    low = 0;
    while (!out_vld && k < 4 * int'(NumIter) + 8) begin
      if (!in_rdy) low++;
      @(posedge clk);
      #1;
      k++;
    end
    exp_res = exp_q.pop_front();
    check_val("latency", 32'(k), 32'(lat_q.pop_front()));
    if (!out_vld) return;
    check_val("result", res, exp_res);
    held = res;
    bad  = 0;
    if (!in_rdy) low++;
    repeat (stall) begin
      @(posedge clk);
      #1;
      if (res !== held || !out_vld || in_rdy) bad++;
      if (!in_rdy) low++;
    end
    if (stall > 0) check_val("stall_stable", 32'(bad), 32'd0);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    check_val("idle_after", 32'({out_vld, in_rdy}), 32'd1);
    check_val("inrdy_low", 32'(low), 32'(k + 1 + stall));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 255));
      5: return 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held, a, b;
    logic [1:0]  op;
    int          vld_seen, stall;
    rst_n   = 1'b0;
    kill    = 1'b0;
    opa     = '0;
    opb     = '0;
    opcode  = '0;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_res", res, 32'd0);
    check_val("reset_flags", 32'({out_vld, in_rdy}), 32'd1);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 2'b00, 32'd14, 0);
    run_op(32'd100, 32'd7, 2'b10, 32'd2, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 2'b01, 32'hFFFF_FFFD, 0);
    run_op(32'hFFFF_FFF9, 32'd2, 2'b11, 32'hFFFF_FFFF, 0);
    run_op(32'd7, 32'hFFFF_FFFE, 2'b11, 32'd1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b01, 32'h8000_0000, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'd0, 0);
    run_op(32'd5, 32'd0, 2'b00, 32'hFFFF_FFFF, 0);
    run_op(32'hFFFF_FFFB, 32'd0, 2'b11, 32'hFFFF_FFFB, 0);
    run_op(32'd5, 32'd0, 2'b01, 32'hFFFF_FFFF, 0);
    run_op(32'd3, 32'hFFFF_FFF6, 2'b01, 32'd0, 0);
    run_op(32'd1000, 32'd3, 2'b00, 32'd333, 10);

    // Kill in the middle of DIVIDE.
    held = res;
    @(negedge clk);
    opa    = 32'd100;
    opb    = 32'd7;
    opcode = 2'b00;
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    #1;
    check_val("kill_idle", 32'({out_vld, in_rdy}), 32'd1);
    check_val("kill_res_kept", res, held);
    vld_seen = 0;
    repeat (NumIter + 5) begin
      @(posedge clk);
      #1;
      if (out_vld) vld_seen++;
    end
    check_val("kill_no_vld", 32'(vld_seen), 32'd0);
    run_op(32'd1000, 32'd10, 2'b00, 32'd100, 0);

    // Kill in IDLE blocks the accept.
    @(negedge clk);
    kill   = 1'b1;
    in_vld = 1'b1;
    opa    = 32'd50;
    opb    = 32'd5;
    #1;
    check_val("kill_inrdy", 32'(in_rdy), 32'd0);
    @(posedge clk);
    #1;
    kill   = 1'b0;
    in_vld = 1'b0;
    #1;
    check_val("kill_no_accept", 32'({out_vld, in_rdy}), 32'd1);

    for (int i = 0; i < 1000; i++) begin
      a     = pick_operand();
      b     = pick_operand();
      op    = 2'($urandom);
      stall = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(a, b, op, ref_div(a, b, op), stall);
    end

    // Asynchronous reset mid-DIVIDE.
    run_op(32'd12345, 32'd67, 2'b00, 32'd184, 0);
    @(negedge clk);
    opa    = 32'hFFFF_0000;
    opb    = 32'd3;
    opcode = 2'b00;
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_res", res, 32'd0);
    check_val("rst_flags", 32'({out_vld, in_rdy}), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd81, 32'd9, 2'b10, 32'd0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
